mem_rsp_demux: RTL and testbench

- Routes responses from the single shared memory port back to one of two requesters: port A (fetch) or port B (load/store).
- The request side is already muxed. This block is the return direction.
- It records each issued request's select bit in an in-order tag FIFO. Each response is steered to the requester at the FIFO head through a registered output stage per port.
- Sits between the memory interface and the fetch/LSU response inputs.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/tag_fifo.sv | 80 ++++++++
 rtl/mem_rsp_demux.sv | 130 +++++++++++++
 tb/tb_mem_rsp_demux.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and defaults for the memory response return path.
//   rsp_port_e            : requester select encoding (A = fetch, B = load/store)
//   MEM_RSP_DEPTH_DEFAULT : default number of outstanding memory requests
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic {
        RSP_PORT_A = 1'b0,
        RSP_PORT_B = 1'b1
    } rsp_port_e;

    localparam int MEM_RSP_DEPTH_DEFAULT = 4;

endpackage : cpu_pkg

// File: rtl/tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// In-order FIFO of 1-bit requester tags. Each entry records which requester
// issued an outstanding memory request.
//
// Parameters:
//   DEPTH    : number of entries (power of two, >= 2)
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset, clears both pointers
//   push     : write push_tag (ignored while full)
//   push_tag : tag to write
//   pop      : retire the head entry (ignored while empty)
//   head     : tag at the read pointer
//   full     : DEPTH entries held
//   empty    : no entries held
//   count    : number of entries held
// -----------------------------------------------------------------------------
module tag_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = MEM_RSP_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  rsp_port_e                  push_tag,
    input  logic                       pop,
    output rsp_port_e                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Pointers carry one extra MSB so that full and empty are distinguishable
    // when the low address bits are equal.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] ptr_diff;
    rsp_port_e     mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    // The push is qualified by the pre-pop full flag: a push and a pop in the
    // same cycle at full drops the push.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign ptr_diff = wr_ptr - rd_ptr;
    assign count    = ptr_diff[CW-1:0];
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Tag storage needs no reset: a slot is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_tag;
        end
    end

endmodule : tag_fifo

// File: rtl/mem_rsp_demux.sv
// -----------------------------------------------------------------------------
// mem_rsp_demux
// Return-direction demux for a shared memory port. The select bit of every
// accepted request is queued in order; each memory response is steered to the
// requester recorded at the queue head through a registered output stage per
// requester (A = fetch, B = load/store). Responses are returned strictly in
// request order, so a stalled head blocks responses for the other requester.
//
// Optional feature macro: MEM_RSP_DEMUX_ERR_EN
//   defined   : o_err is a sticky flag set by a request fire while full or a
//               response while nothing is outstanding; cleared only by reset.
//   undefined : o_err is tied low.
//
// Parameters:
//   N      : response data width
//   DEPTH  : maximum outstanding requests (power of two, >= 2)
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req_fire, i_req_sel   : request accepted by memory and its requester tag
//   o_full, o_count         : tag queue full, outstanding request count
//   i_rsp_valid, i_rsp_data : memory response
//   o_rsp_ready             : response accepted this cycle
//   o_a_valid/o_a_data/i_a_ready : response handshake to requester A
//   o_b_valid/o_b_data/i_b_ready : response handshake to requester B
//   o_err                   : sticky protocol error
// -----------------------------------------------------------------------------
module mem_rsp_demux
    import cpu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = MEM_RSP_DEPTH_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_fire,
    input  logic                       i_req_sel,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    input  logic                       i_rsp_valid,
    input  logic [N-1:0]               i_rsp_data,
    output logic                       o_rsp_ready,
    output logic                       o_a_valid,
    output logic [N-1:0]               o_a_data,
    input  logic                       i_a_ready,
    output logic                       o_b_valid,
    output logic [N-1:0]               o_b_data,
    input  logic                       i_b_ready,
    output logic                       o_err
);

    rsp_port_e    head;
    logic         empty;
    logic         a_free;
    logic         b_free;
    logic         rsp_fire;
    logic         a_vld_p1;
    logic [N-1:0] a_data_p1;
    logic         b_vld_p1;
    logic [N-1:0] b_data_p1;

    tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (i_req_fire),
        .push_tag (rsp_port_e'(i_req_sel)),
        .pop      (rsp_fire),
        .head     (head),
        .full     (o_full),
        .empty    (empty),
        .count    (o_count)
    );

    // An output stage can take a new response if it is empty or its current
    // response is being consumed this very cycle.
    assign a_free = !a_vld_p1 || i_a_ready;
    assign b_free = !b_vld_p1 || i_b_ready;

    assign o_rsp_ready = !empty && ((head == RSP_PORT_A) ? a_free : b_free);
    assign rsp_fire    = i_rsp_valid && o_rsp_ready;

    // ---- stage p0 -> p1: response captured into the head requester's register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_vld_p1  <= 1'b0;
            a_data_p1 <= '0;
        end else if (rsp_fire && (head == RSP_PORT_A)) begin
            a_vld_p1  <= 1'b1;
            a_data_p1 <= i_rsp_data;
        end else if (i_a_ready) begin
            a_vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            b_vld_p1  <= 1'b0;
            b_data_p1 <= '0;
        end else if (rsp_fire && (head == RSP_PORT_B)) begin
            b_vld_p1  <= 1'b1;
            b_data_p1 <= i_rsp_data;
        end else if (i_b_ready) begin
            b_vld_p1  <= 1'b0;
        end
    end

    assign o_a_valid = a_vld_p1;
    assign o_a_data  = a_data_p1;
    assign o_b_valid = b_vld_p1;
    assign o_b_data  = b_data_p1;

`ifdef MEM_RSP_DEMUX_ERR_EN
    logic err_q;

    // Observes the handshakes only; never gates any datapath.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if ((i_req_fire && o_full) || (i_rsp_valid && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule : mem_rsp_demux

// File: tb/tb_mem_rsp_demux.sv
module tb_mem_rsp_demux;
    import cpu_pkg::*;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef MEM_RSP_DEMUX_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_fire;
    logic          req_sel;
    logic          full;
    logic [CW-1:0] count;
    logic          rsp_valid;
    logic [N-1:0]  rsp_data;
    logic          rsp_ready;
    logic          a_valid;
    logic [N-1:0]  a_data;
    logic          a_ready;
    logic          b_valid;
    logic [N-1:0]  b_data;
    logic          b_ready;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] exp_a [$];
    logic [N-1:0] exp_b [$];
    rsp_port_e    tq [$];

    typedef struct {
        logic         fire;
        logic         sel;
        logic         rv;
        logic [N-1:0] data;
        logic         exp_rdy;
        int           sb;       // 0: nothing accepted, 1: goes to A, 2: goes to B
        int           exp_cnt;
        logic         exp_av;
        logic [N-1:0] exp_ad;
        logic         exp_bv;
        logic [N-1:0] exp_bd;
    } vec_t;

    vec_t vt [13];

    mem_rsp_demux #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_fire  (req_fire),
        .i_req_sel   (req_sel),
        .o_full      (full),
        .o_count     (count),
        .i_rsp_valid (rsp_valid),
        .i_rsp_data  (rsp_data),
        .o_rsp_ready (rsp_ready),
        .o_a_valid   (a_valid),
        .o_a_data    (a_data),
        .i_a_ready   (a_ready),
        .o_b_valid   (b_valid),
        .o_b_data    (b_data),
        .i_b_ready   (b_ready),
        .o_err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic f, input logic s, input logic rv, input logic [N-1:0] d,
                                input logic rdy, input int sb, input int cnt,
                                input logic av, input logic [N-1:0] ad,
                                input logic bv, input logic [N-1:0] bd);
        vec_t v;
        v.fire = f; v.sel = s; v.rv = rv; v.data = d;
        v.exp_rdy = rdy; v.sb = sb; v.exp_cnt = cnt;
        v.exp_av = av; v.exp_ad = ad; v.exp_bv = bv; v.exp_bd = bd;
        return v;
    endfunction

    task automatic drive(input logic f, input logic s, input logic rv, input logic [N-1:0] d);
        req_fire  = f;
        req_sel   = s;
        rsp_valid = rv;
        rsp_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input rsp_port_e p, input logic [N-1:0] d);
        if (p == RSP_PORT_A) exp_a.push_back(d);
        else                 exp_b.push_back(d);
    endtask

    task automatic clear_model();
        exp_a.delete();
        exp_b.delete();
        tq.delete();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Beats are consumed at the posedge following a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && a_ready) begin
                if (exp_a.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_a_extra: got 0x%0h, expected no response", a_data);
                end else begin
                    chk("sb_a", a_data, exp_a.pop_front());
                end
            end
            if (b_valid && b_ready) begin
                if (exp_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_b_extra: got 0x%0h, expected no response", b_data);
                end else begin
                    chk("sb_b", b_data, exp_b.pop_front());
                end
            end
        end
    end

    initial begin
        rsp_port_e h;
        logic      s;

        // interleaved routing A,B,A then an empty response, then push+pop at count 2
        vt[0]  = mk(1, 0, 0, 32'h00, 0, 0, 1, 0, 32'h00, 0, 32'h00);
        vt[1]  = mk(1, 1, 0, 32'h00, 1, 0, 2, 0, 32'h00, 0, 32'h00);
        vt[2]  = mk(1, 0, 0, 32'h00, 1, 0, 3, 0, 32'h00, 0, 32'h00);
        vt[3]  = mk(0, 0, 1, 32'h11, 1, 1, 2, 1, 32'h11, 0, 32'h00);
        vt[4]  = mk(0, 0, 1, 32'h22, 1, 2, 1, 0, 32'h00, 1, 32'h22);
        vt[5]  = mk(0, 0, 1, 32'h33, 1, 1, 0, 1, 32'h33, 0, 32'h00);
        vt[6]  = mk(0, 0, 1, 32'h44, 0, 0, 0, 0, 32'h00, 0, 32'h00);
        vt[7]  = mk(1, 0, 0, 32'h00, 0, 0, 1, 0, 32'h00, 0, 32'h00);
        vt[8]  = mk(1, 1, 0, 32'h00, 1, 0, 2, 0, 32'h00, 0, 32'h00);
        vt[9]  = mk(1, 0, 1, 32'h55, 1, 1, 2, 1, 32'h55, 0, 32'h00);
        vt[10] = mk(0, 0, 1, 32'h66, 1, 2, 1, 0, 32'h00, 1, 32'h66);
        vt[11] = mk(0, 0, 1, 32'h77, 1, 1, 0, 1, 32'h77, 0, 32'h00);
        vt[12] = mk(0, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00, 0, 32'h00);

        drive(1'b0, 1'b0, 1'b0, '0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        rst_n   = 1'b0;
        tick();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_err", err, 0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].fire, vt[i].sel, vt[i].rv, vt[i].data);
            if (vt[i].sb == 1) expect_rsp(RSP_PORT_A, vt[i].data);
            if (vt[i].sb == 2) expect_rsp(RSP_PORT_B, vt[i].data);
            #3;
            chk($sformatf("v%0d_ready", i), rsp_ready, vt[i].exp_rdy);
            tick();
            chk($sformatf("v%0d_count", i), count, vt[i].exp_cnt);
            chk($sformatf("v%0d_full", i), full, (vt[i].exp_cnt == DEPTH));
            chk($sformatf("v%0d_a_valid", i), a_valid, vt[i].exp_av);
            chk($sformatf("v%0d_b_valid", i), b_valid, vt[i].exp_bv);
            if (vt[i].exp_av) chk($sformatf("v%0d_a_data", i), a_data, vt[i].exp_ad);
            if (vt[i].exp_bv) chk($sformatf("v%0d_b_data", i), b_data, vt[i].exp_bd);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("empty_rsp_err", err, ERR_EXP);

        // reset mid-stream: 3 outstanding with a response held on A
        a_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 2), 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 32'h99);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("mid_count", count, 3);
        chk("mid_a_valid", a_valid, 1);
        chk("mid_a_data", a_data, 32'h99);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("arst_count", count, 0);
        chk("arst_a_valid", a_valid, 0);
        chk("arst_a_data", a_data, 0);
        chk("arst_full", full, 0);
        chk("arst_err", err, 0);
        tick();
        rst_n   = 1'b1;
        a_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h5A);
        #3;
        chk("post_rst_ready", rsp_ready, 0);
        tick();
        chk("post_rst_a_valid", a_valid, 0);
        chk("post_rst_b_valid", b_valid, 0);
        chk("post_rst_count", count, 0);

        // full and wrap
        do_reset();
        chk("clr_err", err, 0);
        for (int i = 0; i < 4; i++) begin
            s = (i == 1 || i == 2);
            drive(1'b1, s, 1'b0, '0);
            tq.push_back(rsp_port_e'(s));
            tick();
        end
        chk("full_flag", full, 1);
        chk("full_count", count, 4);
        drive(1'b1, 1'b1, 1'b0, '0);
        tick();
        chk("drop_count", count, 4);
        chk("drop_full", full, 1);
        chk("drop_err", err, ERR_EXP);
        drive(1'b1, 1'b0, 1'b1, 32'hC0);
        #3;
        chk("full_pop_ready", rsp_ready, 1);
        h = tq.pop_front();
        expect_rsp(h, 32'hC0);
        tick();
        chk("full_pushpop_count", count, 3);
        chk("full_pushpop_full", full, 0);
        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1));
            drive(1'b1, s, 1'b1, 32'hD0 + i);
            #3;
            chk($sformatf("wrap%0d_ready", i), rsp_ready, 1);
            h = tq.pop_front();
            expect_rsp(h, 32'hD0 + i);
            tq.push_back(rsp_port_e'(s));
            tick();
            chk($sformatf("wrap%0d_count", i), count, 3);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hE0 + i);
            #3;
            chk($sformatf("drain%0d_ready", i), rsp_ready, 1);
            h = tq.pop_front();
            expect_rsp(h, 32'hE0 + i);
            tick();
            chk($sformatf("drain%0d_count", i), count, 2 - i);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("wrap_sb_a_left", exp_a.size(), 0);
        chk("wrap_sb_b_left", exp_b.size(), 0);

        // backpressure / head-of-line blocking: tags A,A,B with A stalled
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 2), 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 32'hAA);
        #3;
        chk("bp_first_ready", rsp_ready, 1);
        expect_rsp(RSP_PORT_A, 32'hAA);
        tick();
        chk("bp_a_valid", a_valid, 1);
        chk("bp_a_data", a_data, 32'hAA);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hBB);
            #3;
            chk($sformatf("bp_block%0d_ready", i), rsp_ready, 0);
            tick();
            chk($sformatf("bp_hold%0d_a_data", i), a_data, 32'hAA);
            chk($sformatf("bp_hold%0d_count", i), count, 2);
        end
        a_ready = 1'b1;
        #3;
        chk("bp_drain_ready", rsp_ready, 1);
        expect_rsp(RSP_PORT_A, 32'hBB);
        tick();
        chk("bp_second_a_data", a_data, 32'hBB);
        chk("bp_second_count", count, 1);
        drive(1'b0, 1'b0, 1'b1, 32'hCC);
        #3;
        chk("bp_b_ready", rsp_ready, 1);
        expect_rsp(RSP_PORT_B, 32'hCC);
        tick();
        chk("bp_b_valid", b_valid, 1);
        chk("bp_b_data", b_data, 32'hCC);
        chk("bp_a_cleared", a_valid, 0);
        chk("bp_count", count, 0);
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        chk("bp_sb_a_left", exp_a.size(), 0);
        chk("bp_sb_b_left", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_rsp_demux
